// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One operation at a time. The latency is fixed at XLEN+2 cycles from the
// accepted start to the done pulse, and the special cases use the same
// latency (there is no early exit).
//
// Handshake: start is sampled only in IDLE or DONE, and only when flush is
// low. While busy is high, start is ignored and is not queued. done is a
// one-cycle pulse. quotient and remainder are valid from the done cycle
// onward and hold their values until the next completed operation.
module div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // The partial remainder is held in XLEN bits. The shifted value and the
    // trial subtraction are XLEN+1 bits wide so the borrow is visible.
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_mag_q, dvs_mag_d;
    logic [XLEN-1:0]   dvd_raw_q, dvd_raw_d;
    logic [XLEN-1:0]   dvs_raw_q, dvs_raw_d;
    logic              sgn_op_q, sgn_op_d;
    logic              sign_q_q, sign_q_d;
    logic              sign_r_q, sign_r_d;
    logic [XLEN-1:0]   quotient_q, quotient_d;
    logic [XLEN-1:0]   remainder_q, remainder_d;

    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic              div_zero;
    logic              sgn_ovf;

    // Datapath: one restoring step, then the sign fixup and the special-case overrides
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_mag_q};
        div_zero  = (dvs_raw_q == '0);
        sgn_ovf   = sgn_op_q && (dvd_raw_q == {1'b1, {(XLEN-1){1'b0}}})
                    && (dvs_raw_q == '1);
        q_fix     = sign_q_q ? (XLEN'(0) - quo_q) : quo_q;
        r_fix     = sign_r_q ? (XLEN'(0) - rem_q) : rem_q;
        if (div_zero) begin
            q_fix = '1;
            r_fix = dvd_raw_q;
        end else if (sgn_ovf) begin
            q_fix = dvd_raw_q;
            r_fix = '0;
        end
    end

    // Next-state and register-update logic for the divider FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_mag_d   = dvs_mag_q;
        dvd_raw_d   = dvd_raw_q;
        dvs_raw_d   = dvs_raw_q;
        sgn_op_d    = sgn_op_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = (is_signed && dividend[XLEN-1]) ? (XLEN'(0) - dividend) : dividend;
                    dvs_mag_d = (is_signed && divisor[XLEN-1]) ? (XLEN'(0) - divisor) : divisor;
                    dvd_raw_d = dividend;
                    dvs_raw_d = divisor;
                    sgn_op_d  = is_signed;
                    sign_q_d  = (is_signed & dividend[XLEN-1]) ^ (is_signed & divisor[XLEN-1]);
                    sign_r_d  = is_signed & dividend[XLEN-1];
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_mag_q   <= '0;
            dvd_raw_q   <= '0;
            dvs_raw_q   <= '0;
            sgn_op_q    <= 1'b0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_mag_q   <= dvs_mag_d;
            dvd_raw_q   <= dvd_raw_d;
            dvs_raw_q   <= dvs_raw_d;
            sgn_op_q    <= sgn_op_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter. Each scenario task drives its own
// stimulus and checks its own expected values.
module tb_div_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic [1:0]  dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam int         LAT     = 34;

    div_iter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    // Advance one cycle and settle just after the active edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
    endtask

    // Start an op in the current cycle, wait for done, then check the latency and the results
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input string name);
        int lat;
        drive_start(s, a, b);
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        total_cnt++;
        if (lat != LAT) $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== eq) $display("FAIL %s quotient: got %h expected %h", name, quotient, eq);
        else pass_cnt++;
        total_cnt++;
        if (remainder !== er) $display("FAIL %s remainder: got %h expected %h", name, remainder, er);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset ctrl: got busy=%b done=%b st=%0d expected 0 0 0", busy, done, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 32'h0 || remainder !== 32'h0)
            $display("FAIL reset results: got q=%h r=%h expected 0 0", quotient, remainder);
        else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_divu_basic();
        drive_start(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 35; c++) begin
            step();
            start = 1'b0;
            total_cnt++;
            if (busy !== (c <= 33)) $display("FAIL divu busy c%0d: got %b expected %b", c, busy, (c <= 33));
            else pass_cnt++;
            total_cnt++;
            if (done !== (c == 34)) $display("FAIL divu done c%0d: got %b expected %b", c, done, (c == 34));
            else pass_cnt++;
            if (c >= 34) begin
                total_cnt++;
                if (quotient !== 32'd14 || remainder !== 32'd2)
                    $display("FAIL divu result c%0d: got q=%h r=%h expected 0000000e 00000002", c, quotient, remainder);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_signed();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, "div_m100_m7");
    endtask

    task automatic test_div_zero();
        run_op(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, "divu_by0");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_by0");
    endtask

    task automatic test_overflow();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_ovf");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "divu_big");
    endtask

    // The second op is started in the done cycle of the first one
    task automatic test_back_to_back();
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "b2b_first");
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "b2b_second");
    endtask

    task automatic test_ignore_start();
        int extra_done;
        drive_start(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 34; c++) begin
            step();
            start = 1'b0;
            if (c == 10) drive_start(1'b0, 32'd1000, 32'd10);
            if (c == 34) begin
                total_cnt++;
                if (done !== 1'b1) $display("FAIL ign done: got %b expected 1", done);
                else pass_cnt++;
                total_cnt++;
                if (quotient !== 32'd14 || remainder !== 32'd2)
                    $display("FAIL ign result: got q=%h r=%h expected 0000000e 00000002", quotient, remainder);
                else pass_cnt++;
            end
        end
        extra_done = 0;
        for (int c = 35; c <= 80; c++) begin
            step();
            if (done === 1'b1) extra_done++;
        end
        total_cnt++;
        if (extra_done != 0) $display("FAIL ign extra done: got %0d pulses expected 0", extra_done);
        else pass_cnt++;
    endtask

    // Expects quotient=14 and remainder=2 left over from the previous op
    task automatic test_flush();
        int seen_done;
        drive_start(1'b0, 32'd50, 32'd5);
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL flush idle: got busy=%b st=%0d expected 0 0", busy, dbg_state);
        else pass_cnt++;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1) seen_done++;
        end
        total_cnt++;
        if (seen_done != 0) $display("FAIL flush done: got %0d pulses expected 0", seen_done);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 32'd14 || remainder !== 32'd2)
            $display("FAIL flush retain: got q=%h r=%h expected 0000000e 00000002", quotient, remainder);
        else pass_cnt++;
        drive_start(1'b0, 32'd50, 32'd5);
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL flush blocks start: got busy=%b st=%0d expected 0 0", busy, dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive_start(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 15; c++) begin
            step();
            start = 1'b0;
        end
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL rst mid ctrl: got busy=%b done=%b st=%0d expected 0 0 0", busy, done, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 32'h0 || remainder !== 32'h0)
            $display("FAIL rst mid results: got q=%h r=%h expected 0 0", quotient, remainder);
        else pass_cnt++;
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, "post_reset");
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
